cache_mem_responder: RTL and testbench



---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_mem_array.sv | 32 +++
 rtl/cache_mem_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for sa_cache and its memory-side responder.
//   - Address field widths of the cache request ({tag, index, offset}).
//   - Word width of the backing store.
//   - State encoding of the responder FSM.
//   - word_sel(): converts a byte address into a word address.
package cache_pkg;

    localparam int TAG_W        = 18;
    localparam int INDEX_W      = 8;
    localparam int OFFSET_W     = 6;
    localparam int ADDR_W_BYTES = 32;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Byte address to word address. Bits [1:0] select a byte within a word
    // and are dropped. Callers truncate the result to the store depth.
    function automatic logic [ADDR_W_BYTES-3:0] word_sel(input logic [ADDR_W_BYTES-1:0] byte_addr);
        return byte_addr[ADDR_W_BYTES-1:2];
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// cache_mem_array: single-port synchronous word RAM, one write enable.
//   clk    in  : clock, rising edge
//   we     in  : write enable; writes wdata to addr on the edge
//   addr   in  : word address (shared by read and write)
//   wdata  in  : write data
//   rdata  out : registered read data (old contents on a write edge)
// Contents are not reset. The declaration initialiser gives zeroed
// contents in simulation.
module cache_mem_array
    import cache_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH] = '{default: '0};

    // Storage write and registered read on the single port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: behavioural backing store below sa_cache.
// Serves level miss requests after READ_LATENCY cycles with a one-cycle
// o_memory_response pulse. Absorbs evictions through a one-entry writeback
// buffer that occupies the store for WB_LATENCY cycles.
// Ports:
//   clk                in  : clock, rising edge
//   rst                in  : synchronous active-low reset
//   cache_miss         in  : miss request, held until served
//   i_tag/i_index/i_offset in : miss byte address fields
//   i_evict            in  : one-cycle eviction strobe
//   i_evict_addr       in  : eviction byte address
//   i_evict_data       in  : eviction data word
//   o_memory_line      out : fill data; zero outside the response cycle
//   o_memory_response  out : one-cycle fill strobe
//   o_busy             out : FSM not idle, or writeback buffer occupied
//   o_evict_ovf        out : sticky; an eviction was dropped (buffer full)
// Optional feature macro CACHE_MEM_STATS_EN adds o_rd_count and o_wb_count,
// 16-bit wrapping counts of responses and completed writebacks.
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 4,
    parameter int WB_LATENCY   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cache_miss,
    input  logic [TAG_W-1:0]        i_tag,
    input  logic [INDEX_W-1:0]      i_index,
    input  logic [OFFSET_W-1:0]     i_offset,
    input  logic                    i_evict,
    input  logic [ADDR_W_BYTES-1:0] i_evict_addr,
    input  logic [WORD_W-1:0]       i_evict_data,
    output logic [WORD_W-1:0]       o_memory_line,
    output logic                    o_memory_response,
    output logic                    o_busy,
`ifdef CACHE_MEM_STATS_EN
    output logic [15:0]             o_rd_count,
    output logic [15:0]             o_wb_count,
`endif
    output logic                    o_evict_ovf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WB_LOAD = 8'(WB_LATENCY - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wb_full_q, wb_full_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [WORD_W-1:0]   wb_data_q, wb_data_d;
    logic                served_q, served_d;
    logic                ovf_q, ovf_d;
    logic [WORD_W-1:0]   line_q, line_d;
    logic                resp_q, resp_d;
    logic                busy_q, busy_d;

    logic [ADDR_W_BYTES-1:0] miss_addr_s;
    logic [ADDR_W_BYTES-3:0] miss_word_full_s;
    logic [ADDR_W_BYTES-3:0] evict_word_full_s;
    logic [ADDR_W-1:0]       miss_word_s;
    logic [ADDR_W-1:0]       evict_word_s;
    logic                    ram_we_s;
    logic [ADDR_W-1:0]       ram_addr_s;
    logic [WORD_W-1:0]       ram_rdata_s;
    logic                    unused_addr_bits_s;

    // Byte-to-word address decode; upper bits alias by truncation.
    always_comb begin
        miss_addr_s       = {i_tag, i_index, i_offset};
        miss_word_full_s  = word_sel(miss_addr_s);
        evict_word_full_s = word_sel(i_evict_addr);
        miss_word_s       = miss_word_full_s[ADDR_W-1:0];
        evict_word_s      = evict_word_full_s[ADDR_W-1:0];
    end

    assign unused_addr_bits_s = ^{miss_addr_s, i_evict_addr};

    // Next-state, writeback buffer, served flag and output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wb_full_d = wb_full_q;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        ovf_d     = ovf_q;
        line_d    = {WORD_W{1'b0}};
        resp_d    = 1'b0;
        ram_we_s  = 1'b0;
        ram_addr_s = miss_word_s;

        // A dropped miss must go low for a cycle before it can be re-accepted.
        if (cache_miss) begin
            served_d = served_q;
        end else begin
            served_d = 1'b0;
        end

        // The buffer takes an eviction in any state, but only when empty.
        if (i_evict && !wb_full_q) begin
            wb_full_d = 1'b1;
            wb_addr_d = evict_word_s;
            wb_data_d = i_evict_data;
        end else if (i_evict && wb_full_q) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            IDLE: begin
                if (wb_full_q || i_evict) begin
                    state_d = WB;
                    cnt_d   = WB_LOAD;
                end else if (cache_miss && !served_q) begin
                    state_d = RD;
                    cnt_d   = RD_LOAD;
                    addr_d  = miss_word_s;
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                ram_addr_s = wb_addr_q;
                if (cnt_q == 8'd0) begin
                    ram_we_s  = 1'b1;
                    wb_full_d = 1'b0;
                    // A miss waiting behind the writeback starts its read on the
                    // write edge, so its latency is exactly WB + READ. With a
                    // one-cycle read the RAM port is still busy with the write,
                    // so that case goes through IDLE instead.
                    if ((READ_LATENCY > 1) && cache_miss && !served_q) begin
                        state_d = RD;
                        cnt_d   = RD_LOAD;
                        addr_d  = miss_word_s;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RD: begin
                ram_addr_s = addr_q;
                if (cnt_q == 8'd0) begin
                    line_d  = ram_rdata_s;
                    resp_d  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                served_d = cache_miss;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || wb_full_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            addr_q    <= {ADDR_W{1'b0}};
            wb_full_q <= 1'b0;
            wb_addr_q <= {ADDR_W{1'b0}};
            wb_data_q <= {WORD_W{1'b0}};
            served_q  <= 1'b0;
            ovf_q     <= 1'b0;
            line_q    <= {WORD_W{1'b0}};
            resp_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wb_full_q <= wb_full_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            served_q  <= served_d;
            ovf_q     <= ovf_d;
            line_q    <= line_d;
            resp_q    <= resp_d;
            busy_q    <= busy_d;
        end
    end

    // Writes are gated by reset so a stale state cannot write during reset.
    cache_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we_s && rst),
        .addr  (ram_addr_s),
        .wdata (wb_data_q),
        .rdata (ram_rdata_s)
    );

    assign o_memory_line     = line_q;
    assign o_memory_response = resp_q;
    assign o_busy            = busy_q;
    assign o_evict_ovf       = ovf_q;

`ifdef CACHE_MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wb_count_q, wb_count_d;

    // Statistics next values; both wrap naturally at 16'hFFFF.
    always_comb begin
        if (state_q == RESP) begin
            rd_count_d = rd_count_q + 16'd1;
        end else begin
            rd_count_d = rd_count_q;
        end
        if (ram_we_s) begin
            wb_count_d = wb_count_q + 16'd1;
        end else begin
            wb_count_d = wb_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_count_q <= 16'd0;
            wb_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign o_rd_count = rd_count_q;
    assign o_wb_count = wb_count_q;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder (default parameters).
module tb_cache_mem_responder;

    localparam int RL = 4;
    localparam int WL = 2;

    logic        clk;
    logic        rst;
    logic        cache_miss;
    logic [17:0] i_tag;
    logic [7:0]  i_index;
    logic [5:0]  i_offset;
    logic        i_evict;
    logic [31:0] i_evict_addr;
    logic [31:0] i_evict_data;
    logic [31:0] o_memory_line;
    logic        o_memory_response;
    logic        o_busy;
    logic        o_evict_ovf;
`ifdef CACHE_MEM_STATS_EN
    logic [15:0] o_rd_count;
    logic [15:0] o_wb_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int resp_count = 0;
    bit mon_en = 1'b0;
    logic [31:0] exp_q [$];

    cache_mem_responder #(
        .DEPTH        (1024),
        .READ_LATENCY (RL),
        .WB_LATENCY   (WL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cache_miss        (cache_miss),
        .i_tag             (i_tag),
        .i_index           (i_index),
        .i_offset          (i_offset),
        .i_evict           (i_evict),
        .i_evict_addr      (i_evict_addr),
        .i_evict_data      (i_evict_data),
        .o_memory_line     (o_memory_line),
        .o_memory_response (o_memory_response),
        .o_busy            (o_busy),
`ifdef CACHE_MEM_STATS_EN
        .o_rd_count        (o_rd_count),
        .o_wb_count        (o_wb_count),
`endif
        .o_evict_ovf       (o_evict_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every response pops one expected fill word;
    // outside a response the line must read zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_memory_response === 1'b1) begin
                resp_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_resp: observed response with line %h expected no response", o_memory_line);
                end else begin
                    check("fill_data", o_memory_line, exp_q.pop_front());
                end
            end else begin
                check("line_idle_zero", o_memory_line, 32'h0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_memory_response === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout: observed no response expected one within 40 cycles", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s_busy_timeout: observed o_busy=%b expected 0 within 40 cycles", tag, o_busy);
        end
    endtask

    task automatic set_miss_addr(input logic [31:0] a);
        i_tag    = a[31:14];
        i_index  = a[13:6];
        i_offset = a[5:0];
    endtask

    // Raise a miss, expect fill data exp after lat cycles, then drop the miss.
    task automatic do_miss(input string tag, input logic [31:0] a, input logic [31:0] exp, input int lat);
        int k;
        int at;
        set_miss_addr(a);
        cache_miss = 1'b1;
        exp_q.push_back(exp);
        k = cyc;
        wait_resp(tag, at);
        check({tag, "_latency"}, at, k + 1 + lat);
        cache_miss = 1'b0;
        step();
    endtask

    initial begin
        int k;
        int at;
        int rc;

        // Reset held with both requests asserted.
        rst          = 1'b0;
        cache_miss   = 1'b1;
        i_evict      = 1'b1;
        i_evict_addr = 32'h0000_0100;
        i_evict_data = 32'h1111_1111;
        set_miss_addr(32'h0000_0100);
        step();
        mon_en = 1'b1;
        step();
        check("rst_resp", o_memory_response, 32'h0);
        check("rst_line", o_memory_line, 32'h0);
        check("rst_busy", o_busy, 32'h0);
        check("rst_ovf", o_evict_ovf, 32'h0);
        cache_miss = 1'b0;
        i_evict    = 1'b0;
        rst        = 1'b1;
        step();
        check("post_rst_ovf", o_evict_ovf, 32'h0);
        check("post_rst_busy", o_busy, 32'h0);

        // Writeback then read of the same word.
        i_evict      = 1'b1;
        i_evict_addr = 32'h0000_0040;
        i_evict_data = 32'hDEAD_BEEF;
        step();
        i_evict = 1'b0;
        check("wb_busy", o_busy, 32'h1);
        wait_idle("wb");
        do_miss("wb_then_rd", 32'h0000_0040, 32'hDEAD_BEEF, RL);

        // Simultaneous eviction and miss to the same word, then held miss.
        rc = resp_count;
        i_evict      = 1'b1;
        i_evict_addr = 32'h0000_0080;
        i_evict_data = 32'hCAFE_F00D;
        set_miss_addr(32'h0000_0080);
        cache_miss = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        k = cyc;
        step();
        i_evict = 1'b0;
        wait_resp("simul", at);
        check("simul_latency", at, k + 1 + WL + RL);
        repeat (4) @(negedge clk);
        check("held_single_resp", resp_count, rc + 1);
        check("held_not_busy", o_busy, 32'h0);
        cache_miss = 1'b0;
        @(negedge clk);
        cache_miss = 1'b1;
        exp_q.push_back(32'hCAFE_F00D);
        k = cyc;
        wait_resp("rearm", at);
        check("rearm_latency", at, k + 1 + RL);
        cache_miss = 1'b0;
        step();

        // Overflow: two evictions during one read.
        set_miss_addr(32'h0000_0040);
        cache_miss = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        k = cyc;
        step();
        i_evict      = 1'b1;
        i_evict_addr = 32'h0000_0200;
        i_evict_data = 32'h1234_5678;
        step();
        i_evict_addr = 32'h0000_0240;
        i_evict_data = 32'h9ABC_DEF0;
        step();
        i_evict = 1'b0;
        check("ovf_set", o_evict_ovf, 32'h1);
        check("ovf_busy", o_busy, 32'h1);
        wait_resp("ovf_rd", at);
        check("ovf_rd_latency", at, k + 1 + RL);
        cache_miss = 1'b0;
        wait_idle("ovf_wb");
        do_miss("buffered_evict", 32'h0000_0200, 32'h1234_5678, RL);
        do_miss("dropped_evict", 32'h0000_0240, 32'h0000_0000, RL);
        check("ovf_sticky", o_evict_ovf, 32'h1);

        // Reset in the middle of a read.
        rc = resp_count;
        set_miss_addr(32'h0000_0100);
        cache_miss = 1'b1;
        step();
        step();
        rst        = 1'b0;
        cache_miss = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("midrd_busy", o_busy, 32'h0);
        check("midrd_ovf_cleared", o_evict_ovf, 32'h0);
        repeat (6) @(negedge clk);
        check("midrd_no_resp", resp_count, rc);
        do_miss("after_reset", 32'h0000_0100, 32'h0000_0000, RL);
        do_miss("store_kept", 32'h0000_0080, 32'hCAFE_F00D, RL);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
